// File: rtl/decode_stage_buffered.sv
// Buffered N-wide decode stage. Fetch bundles are decoded into a DEPTH-entry
// bundle FIFO; the oldest undispatched slots are presented compacted to slot 0.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package decode_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } aligned_instr_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } decoded_instr_t;
endpackage

module instr_field_decoder
   import decode_pkg::*;
(
   input  aligned_instr_t instr_i,
   output decoded_instr_t dec_o
);
   always_comb begin
      dec_o        = '0;
      dec_o.valid  = instr_i.valid;
      dec_o.pc     = instr_i.pc;
      dec_o.opcode = instr_i.instr[6:0];
      dec_o.rd     = instr_i.instr[11:7];
      dec_o.funct3 = instr_i.instr[14:12];
      dec_o.rs1    = instr_i.instr[19:15];
      dec_o.rs2    = instr_i.instr[24:20];
      dec_o.funct7 = instr_i.instr[31:25];
      dec_o.imm    = {{20{instr_i.instr[31]}}, instr_i.instr[31:20]};
   end
endmodule

module decode_stage_buffered
   import decode_pkg::*;
#(
   parameter int  WIDTH = `FETCH_WIDTH,
   parameter int  DEPTH = 2,
   localparam int CNTW  = $clog2(WIDTH+1)
)(
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_flush,
   input  logic                        i_stall,
   input  logic                        i_can_dequeue,
   input  aligned_instr_t [WIDTH-1:0]  i_instrs,
   output logic                        o_dequeue,
   output logic                        o_valid,
   output logic [CNTW-1:0]             o_count,
   output logic [WIDTH-1:0]            o_valid_mask,
   output decoded_instr_t [WIDTH-1:0]  o_instrs,
   input  logic [CNTW-1:0]             i_accept
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH+1);
   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);

   decoded_instr_t [WIDTH-1:0] dec;
   decoded_instr_t [WIDTH-1:0] buf_q [DEPTH];
   logic [CNTW-1:0] cnt_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic [CNTW-1:0] head_off_q, head_off_d;
   logic [CNTW-1:0] n_in, rem, acc;
   logic [SW-1:0]   idx;
   logic            push, pop, consume;

   for (genvar s = 0; s < WIDTH; s++) begin : g_dec
      instr_field_decoder u_dec (.instr_i(i_instrs[s]), .dec_o(dec[s]));
   end

   always_comb begin
      n_in = '0;
      for (int s = 0; s < WIDTH; s++) n_in = n_in + CNTW'(i_instrs[s].valid);
   end

   // Registered occupancy only: a full buffer never accepts, even if the head pops now.
   assign o_dequeue = i_can_dequeue & ~i_stall & ~i_flush & i_rst_n & (occ_q < OW'(DEPTH));
   assign push      = o_dequeue & i_instrs[0].valid;

   assign o_valid = (occ_q != '0);
   assign rem     = o_valid ? (cnt_q[rd_ptr_q] - head_off_q) : '0;
   assign o_count = rem;

   always_comb begin
      o_instrs     = '0;
      o_valid_mask = '0;
      idx          = '0;
      for (int s = 0; s < WIDTH; s++) begin
         if (CNTW'(s) < rem) begin
            idx             = SW'(s + int'(head_off_q));
            o_valid_mask[s] = 1'b1;
            o_instrs[s]     = buf_q[rd_ptr_q][idx];
         end
      end
   end

   assign consume = ~i_stall & ~i_flush & o_valid;
   assign acc     = (i_accept > rem) ? rem : i_accept;
   assign pop     = consume & (acc == rem);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      head_off_d = head_off_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop) begin
         rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         head_off_d = '0;
      end else if (consume) begin
         head_off_d = head_off_q + acc;
      end
      if (push && !pop)      occ_d = occ_q + 1'b1;
      else if (pop && !push) occ_d = occ_q - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         head_off_q <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            buf_q[e] <= '0;
            cnt_q[e] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         head_off_q <= head_off_d;
         if (push) begin
            buf_q[wr_ptr_q] <= dec;
            cnt_q[wr_ptr_q] <= n_in;
         end
      end
   end
endmodule

// File: tb/tb_decode_stage_buffered.sv
// Directed bench for decode_stage_buffered: cycle table plus latency and
// in-order partial-dispatch sequences (WIDTH=4, DEPTH=2).
module tb_decode_stage_buffered;
   import decode_pkg::*;
   localparam int W  = 4;
   localparam int D  = 2;
   localparam int CW = $clog2(W+1);

   logic                   i_clk = 1'b0;
   logic                   i_rst_n, i_flush, i_stall, i_can_dequeue;
   aligned_instr_t [W-1:0] i_instrs;
   logic                   o_dequeue, o_valid;
   logic [CW-1:0]          o_count, i_accept;
   logic [W-1:0]           o_valid_mask;
   decoded_instr_t [W-1:0] o_instrs;

   int n_chk = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   decode_stage_buffered #(.WIDTH(W), .DEPTH(D)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_stall(i_stall),
      .i_can_dequeue(i_can_dequeue), .i_instrs(i_instrs), .o_dequeue(o_dequeue),
      .o_valid(o_valid), .o_count(o_count), .o_valid_mask(o_valid_mask),
      .o_instrs(o_instrs), .i_accept(i_accept)
   );

   typedef struct {
      bit       rst_n, flush, stall, cdq;
      bit [3:0] vm;
      int       tag, acc;
      bit       e_deq;
      int       e_cnt;
      bit [3:0] e_mask;
      int       e_tag, e_off;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [6:0] f7_of(int t, int k);
      logic [31:0] tt;
      tt = t;
      return {tt[0], 6'(t + k)};
   endfunction

   function automatic aligned_instr_t mk(int t, int k, bit v);
      aligned_instr_t a;
      a.valid = v;
      a.pc    = 32'h1000 * t + 4 * k;
      a.instr = {f7_of(t, k), 5'(k + 1), 5'(t), 3'(k), 5'(t + k + 2), 7'(7'h13 ^ k)};
      return a;
   endfunction

   function automatic decoded_instr_t exp_dec(int t, int k);
      decoded_instr_t d;
      d.valid  = 1'b1;
      d.pc     = 32'h1000 * t + 4 * k;
      d.opcode = 7'(7'h13 ^ k);
      d.rd     = 5'(t + k + 2);
      d.funct3 = 3'(k);
      d.rs1    = 5'(t);
      d.rs2    = 5'(k + 1);
      d.funct7 = f7_of(t, k);
      d.imm    = {{20{d.funct7[6]}}, d.funct7, 5'(k + 1)};
      return d;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(bit rst_n, bit flush, bit stall, bit cdq, bit [3:0] vm, int tag, int acc);
      assert ((vm & (vm + 4'd1)) == 4'd0) else $error("non-prefix bundle in stimulus");
      i_rst_n       = rst_n;
      i_flush       = flush;
      i_stall       = stall;
      i_can_dequeue = cdq;
      i_accept      = CW'(acc);
      for (int k = 0; k < W; k++) i_instrs[k] = mk(tag, k, vm[k]);
   endtask

   task automatic add(bit rst_n, bit flush, bit stall, bit cdq, bit [3:0] vm, int tag, int acc,
                      bit e_deq, int e_cnt, bit [3:0] e_mask, int e_tag, int e_off);
      vec_t v;
      v.rst_n = rst_n; v.flush = flush; v.stall = stall; v.cdq = cdq; v.vm = vm;
      v.tag = tag; v.acc = acc; v.e_deq = e_deq; v.e_cnt = e_cnt; v.e_mask = e_mask;
      v.e_tag = e_tag; v.e_off = e_off;
      tbl.push_back(v);
   endtask

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [31:0] got[$];
      logic [31:0] want[$];
      int cyc, tag_next, take;

      //  rst fl st cdq vm   tag acc  deq cnt mask  etag off
      // streaming
      add(1, 0, 0, 1, 4'hF,  1, 4,   1, 0, 4'h0,  0, 0);
      add(1, 0, 0, 1, 4'hF,  2, 4,   1, 4, 4'hF,  1, 0);
      add(1, 0, 0, 1, 4'hF,  3, 4,   1, 4, 4'hF,  2, 0);
      add(1, 0, 0, 0, 4'hF,  3, 4,   0, 4, 4'hF,  3, 0);
      add(1, 0, 0, 0, 4'hF,  3, 0,   0, 0, 4'h0,  0, 0);
      // partial dispatch 1,2,3
      add(1, 0, 0, 1, 4'hF,  4, 0,   1, 0, 4'h0,  0, 0);
      add(1, 0, 0, 0, 4'hF,  4, 1,   0, 4, 4'hF,  4, 0);
      add(1, 0, 0, 0, 4'hF,  4, 2,   0, 3, 4'h7,  4, 1);
      add(1, 0, 0, 0, 4'hF,  4, 3,   0, 1, 4'h1,  4, 3);
      add(1, 0, 0, 0, 4'hF,  4, 0,   0, 0, 4'h0,  0, 0);
      // full / backpressure
      add(1, 0, 0, 1, 4'hF,  5, 0,   1, 0, 4'h0,  0, 0);
      add(1, 0, 0, 1, 4'hF,  6, 0,   1, 4, 4'hF,  5, 0);
      add(1, 0, 0, 1, 4'hF,  7, 0,   0, 4, 4'hF,  5, 0);
      add(1, 0, 0, 1, 4'hF,  7, 4,   0, 4, 4'hF,  5, 0);
      add(1, 0, 0, 1, 4'hF,  7, 0,   1, 4, 4'hF,  6, 0);
      // stall with full buffer
      add(1, 0, 1, 1, 4'hF,  8, 4,   0, 4, 4'hF,  6, 0);
      add(1, 0, 1, 1, 4'hF,  8, 4,   0, 4, 4'hF,  6, 0);
      add(1, 0, 1, 1, 4'hF,  8, 4,   0, 4, 4'hF,  6, 0);
      add(1, 0, 0, 0, 4'hF,  8, 4,   0, 4, 4'hF,  6, 0);
      add(1, 0, 0, 0, 4'hF,  8, 4,   0, 4, 4'hF,  7, 0);
      // bubble, then 2-slot prefix with clipped accept
      add(1, 0, 0, 1, 4'h0,  9, 4,   1, 0, 4'h0,  0, 0);
      add(1, 0, 0, 1, 4'h3, 10, 4,   1, 0, 4'h0,  0, 0);
      add(1, 0, 0, 0, 4'h3, 10, 3,   0, 2, 4'h3, 10, 0);
      add(1, 0, 0, 0, 4'h3, 10, 0,   0, 0, 4'h0,  0, 0);
      // flush during stall with occ=2, head_off=1
      add(1, 0, 0, 1, 4'hF, 11, 0,   1, 0, 4'h0,  0, 0);
      add(1, 0, 0, 1, 4'hF, 12, 1,   1, 4, 4'hF, 11, 0);
      add(1, 0, 0, 1, 4'hF, 13, 0,   0, 3, 4'h7, 11, 1);
      add(1, 1, 1, 1, 4'hF, 13, 4,   0, 3, 4'h7, 11, 1);
      add(1, 0, 0, 0, 4'hF, 13, 0,   0, 0, 4'h0,  0, 0);
      // same with reset
      add(1, 0, 0, 1, 4'hF, 14, 0,   1, 0, 4'h0,  0, 0);
      add(1, 0, 0, 1, 4'hF, 15, 1,   1, 4, 4'hF, 14, 0);
      add(1, 0, 0, 1, 4'hF, 16, 0,   0, 3, 4'h7, 14, 1);
      add(0, 0, 1, 1, 4'hF, 16, 4,   0, 3, 4'h7, 14, 1);
      add(1, 0, 0, 0, 4'hF, 16, 0,   0, 0, 4'h0,  0, 0);
      // single-slot bundle after reset, accept 4 clipped to 1
      add(1, 0, 0, 1, 4'h1, 17, 0,   1, 0, 4'h0,  0, 0);
      add(1, 0, 0, 0, 4'h1, 17, 4,   0, 1, 4'h1, 17, 0);
      add(1, 0, 0, 0, 4'h1, 17, 0,   0, 0, 4'h0,  0, 0);

      drive(0, 0, 0, 0, 4'h0, 0, 0);
      next_cycle();
      next_cycle();

      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].flush, tbl[i].stall, tbl[i].cdq, tbl[i].vm, tbl[i].tag, tbl[i].acc);
         #1;
         chk($sformatf("v%0d.dequeue", i), 128'(o_dequeue), 128'(tbl[i].e_deq));
         chk($sformatf("v%0d.valid", i), 128'(o_valid), 128'(tbl[i].e_cnt != 0));
         chk($sformatf("v%0d.count", i), 128'(o_count), 128'(tbl[i].e_cnt));
         chk($sformatf("v%0d.mask", i), 128'(o_valid_mask), 128'(tbl[i].e_mask));
         for (int s = 0; s < W; s++) begin
            if (s < tbl[i].e_cnt)
               chk($sformatf("v%0d.slot%0d", i, s), 128'(o_instrs[s]),
                   128'(exp_dec(tbl[i].e_tag, tbl[i].e_off + s)));
            else
               chk($sformatf("v%0d.slot%0d", i, s), 128'(o_instrs[s]), 128'(0));
         end
         next_cycle();
      end

      // Latency from empty: presentable the cycle after dequeue.
      drive(1, 0, 0, 1, 4'hF, 20, 0);
      #1;
      chk("lat.dequeue", 128'(o_dequeue), 128'(1));
      next_cycle();
      drive(1, 0, 0, 0, 4'hF, 20, 0);
      cyc = 0;
      #1;
      while (!o_valid && cyc < 8) begin
         next_cycle();
         cyc++;
      end
      chk("lat.cycles", 128'(cyc), 128'(0));
      chk("lat.slot0", 128'(o_instrs[0]), 128'(exp_dec(20, 0)));
      drive(1, 0, 0, 0, 4'hF, 20, 4);
      next_cycle();

      // Three bundles drained two slots per cycle: strict program order.
      for (int t = 21; t <= 23; t++)
         for (int k = 0; k < W; k++) want.push_back(32'h1000 * t + 4 * k);
      tag_next = 21;
      cyc = 0;
      while (got.size() < 12 && cyc < 30) begin
         drive(1, 0, 0, tag_next <= 23, 4'hF, tag_next, 2);
         #1;
         take = (int'(o_count) < 2) ? int'(o_count) : 2;
         for (int s = 0; s < take; s++) got.push_back(o_instrs[s].pc);
         if (o_dequeue) tag_next++;
         next_cycle();
         cyc++;
      end
      chk("order.len", 128'(got.size()), 128'(12));
      for (int j = 0; j < 12; j++)
         chk($sformatf("order.pc%0d", j), (j < got.size()) ? 128'(got[j]) : 128'hx, 128'(want[j]));
      drive(1, 0, 0, 0, 4'h0, 0, 0);
      #1;
      chk("order.empty", 128'(o_valid), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
